// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler for the chess-timer character LCD: driver reset, init sequence,
// then two 10-character time lines redrawn on input change or periodic refresh.
module lcd_frame_scheduler #(
    parameter int RST_CYCLES     = 16,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_a,
    input  logic [23:0] time_b,
    input  logic        active_b,
    input  logic        set_mode,
    input  logic        lcd_rdy,
    output logic        lcd_rst,
    output logic        lcd_enb,
    output logic        lcd_oper,
    output logic [7:0]  lcd_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_DRV_RST,
        S_INIT,
        S_IDLE,
        S_LINE1_ADDR,
        S_LINE1_CHARS,
        S_LINE2_ADDR,
        S_LINE2_CHARS
    } state_t;

    localparam int                RST_W        = $clog2(RST_CYCLES) + 1;
    localparam logic [RST_W-1:0]  RST_LAST     = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               hold_q, hold_d;
    logic [CNT_W-1:0]   refresh_q, refresh_d;
    logic               snap_vld_q, snap_vld_d;
    logic [23:0]        snap_a_q, snap_a_d;
    logic [23:0]        snap_b_q, snap_b_d;
    logic               snap_act_q, snap_act_d;
    logic               snap_set_q, snap_set_d;
    logic               oper_q, oper_d;
    logic [7:0]         data_q, data_d;

    logic               issue_state;
    logic               fire;
    logic               live_diff;
    logic               frame_start;
    logic               cur_oper;
    logic [7:0]         cur_byte;

    function automatic logic [7:0] digit_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] line_char(input logic [23:0] t,
                                             input logic        running,
                                             input logic        set_md,
                                             input logic [3:0]  idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = set_md ? 8'h2A : (running ? 8'h3E : 8'h20);
            4'd1:    c = 8'h20;
            4'd2:    c = digit_char(t[23:20]);
            4'd3:    c = digit_char(t[19:16]);
            4'd4:    c = 8'h3A;
            4'd5:    c = digit_char(t[15:12]);
            4'd6:    c = digit_char(t[11:8]);
            4'd7:    c = 8'h3A;
            4'd8:    c = digit_char(t[7:4]);
            4'd9:    c = digit_char(t[3:0]);
            default: c = 8'h20;
        endcase
        return c;
    endfunction

    // Byte presented in the current issue cycle; frame bytes come only from the snapshot.
    always_comb begin
        cur_oper = 1'b0;
        cur_byte = 8'h00;
        case (state_q)
            S_INIT: begin
                case (idx_q)
                    4'd0:    cur_byte = 8'h38;
                    4'd1:    cur_byte = 8'h0C;
                    4'd2:    cur_byte = 8'h06;
                    default: cur_byte = 8'h01;
                endcase
            end
            S_LINE1_ADDR:  cur_byte = 8'h80;
            S_LINE1_CHARS: begin
                cur_oper = 1'b1;
                cur_byte = line_char(snap_a_q, !snap_act_q, snap_set_q, idx_q);
            end
            S_LINE2_ADDR:  cur_byte = 8'hC0;
            S_LINE2_CHARS: begin
                cur_oper = 1'b1;
                cur_byte = line_char(snap_b_q, snap_act_q, snap_set_q, idx_q);
            end
            default: begin
                cur_oper = 1'b0;
                cur_byte = 8'h00;
            end
        endcase
    end

    assign issue_state = (state_q == S_INIT) || (state_q == S_LINE1_ADDR) ||
                         (state_q == S_LINE1_CHARS) || (state_q == S_LINE2_ADDR) ||
                         (state_q == S_LINE2_CHARS);
    assign fire        = issue_state && !hold_q && lcd_rdy;
    assign live_diff   = {time_a, time_b, active_b, set_mode} !=
                         {snap_a_q, snap_b_q, snap_act_q, snap_set_q};
    // An empty snapshot forces the first frame after init regardless of input values.
    assign frame_start = (state_q == S_IDLE) &&
                         (!snap_vld_q || live_diff || (refresh_q == REFRESH_LAST));

    // Sequencing advances in the HOLD cycle that follows each issue.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        idx_d      = idx_q;
        hold_d     = fire;
        refresh_d  = refresh_q;
        snap_vld_d = snap_vld_q;
        snap_a_d   = snap_a_q;
        snap_b_d   = snap_b_q;
        snap_act_d = snap_act_q;
        snap_set_d = snap_set_q;
        oper_d     = oper_q;
        data_d     = data_q;

        case (state_q)
            S_DRV_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_INIT;
                    rst_cnt_d = '0;
                    idx_d     = 4'd0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_INIT: begin
                if (hold_q) begin
                    if (idx_q == 4'd3) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_LINE1_ADDR;
                    snap_vld_d = 1'b1;
                    snap_a_d   = time_a;
                    snap_b_d   = time_b;
                    snap_act_d = active_b;
                    snap_set_d = set_mode;
                    refresh_d  = '0;
                    idx_d      = 4'd0;
                end else if (refresh_q != REFRESH_LAST) begin
                    refresh_d = refresh_q + CNT_W'(1);
                end
            end
            S_LINE1_ADDR: begin
                if (hold_q) begin
                    state_d = S_LINE1_CHARS;
                    idx_d   = 4'd0;
                end
            end
            S_LINE1_CHARS: begin
                if (hold_q) begin
                    if (idx_q == 4'd9) begin
                        state_d = S_LINE2_ADDR;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_LINE2_ADDR: begin
                if (hold_q) begin
                    state_d = S_LINE2_CHARS;
                    idx_d   = 4'd0;
                end
            end
            S_LINE2_CHARS: begin
                if (hold_q) begin
                    if (idx_q == 4'd9) begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_DRV_RST;
        endcase

        if (fire) begin
            oper_d = cur_oper;
            data_d = cur_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_DRV_RST;
            rst_cnt_q  <= '0;
            idx_q      <= 4'd0;
            hold_q     <= 1'b0;
            refresh_q  <= '0;
            snap_vld_q <= 1'b0;
            oper_q     <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            refresh_q  <= refresh_d;
            snap_vld_q <= snap_vld_d;
            oper_q     <= oper_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_a_q   <= snap_a_d;
        snap_b_q   <= snap_b_d;
        snap_act_q <= snap_act_d;
        snap_set_q <= snap_set_d;
    end

    assign lcd_rst    = (state_q == S_DRV_RST);
    assign lcd_enb    = fire;
    assign lcd_oper   = fire ? cur_oper : oper_q;
    assign lcd_data   = fire ? cur_byte : data_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_LINE2_CHARS) && hold_q && (idx_q == 4'd9);

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler: reset/init, frame content, throttling,
// snapshot isolation, markers, periodic refresh and mid-frame reset.
module tb_lcd_frame_scheduler;

    localparam int RST_C = 16;
    localparam int REF_C = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] time_a;
    logic [23:0] time_b;
    logic        active_b;
    logic        set_mode;
    logic        lcd_rdy;
    logic        lcd_rst;
    logic        lcd_enb;
    logic        lcd_oper;
    logic [7:0]  lcd_data;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic       oper;
        logic [7:0] data;
        int         cyc;
    } xfer_t;

    xfer_t q[$];
    int    cyc = 0;
    int    fd_cnt = 0;
    int    fd_cyc = 0;
    int    rdy_viol = 0;
    int    consec_viol = 0;
    logic  prev_enb = 1'b0;
    int    checks = 0;
    int    errors = 0;

    lcd_frame_scheduler #(
        .RST_CYCLES    (RST_C),
        .REFRESH_CYCLES(REF_C),
        .CNT_W         (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .time_a    (time_a),
        .time_b    (time_b),
        .active_b  (active_b),
        .set_mode  (set_mode),
        .lcd_rdy   (lcd_rdy),
        .lcd_rst   (lcd_rst),
        .lcd_enb   (lcd_enb),
        .lcd_oper  (lcd_oper),
        .lcd_data  (lcd_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_enb) begin
            q.push_back('{lcd_oper, lcd_data, cyc});
            if (!lcd_rdy) rdy_viol <= rdy_viol + 1;
            if (prev_enb) consec_viol <= consec_viol + 1;
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        prev_enb <= lcd_enb;
    end

    // Expected {oper,data} for transfer i of a frame showing lines l1 and l2.
    function automatic logic [8:0] exp_byte(input string l1, input string l2, input int i);
        if (i == 0) return 9'h080;
        if (i <= 10) return {1'b1, 8'(l1[i-1])};
        if (i == 11) return 9'h0C0;
        return {1'b1, 8'(l2[i-12])};
    endfunction

    task automatic wait_strobes(input int n, input int budget, output bit to);
        int cnt = 0;
        while (q.size() < n && cnt < budget) begin
            @(posedge clk);
            cnt++;
        end
        to = (q.size() < n);
    endtask

    task automatic count_rst_cycles(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_rst) n++;
            else break;
        end
    endtask

    task automatic test_reset;
        int n;
        bit to;
        logic [7:0] init_b [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        rst = 1'b1;
        lcd_rdy = 1'b1;
        time_a = 24'h001530;
        time_b = 24'h012000;
        active_b = 1'b0;
        set_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lcd_rst, lcd_enb, lcd_oper, lcd_data, busy, frame_done} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rst=%b enb=%b oper=%b data=%h busy=%b fd=%b need 1 0 0 00 1 0",
                     lcd_rst, lcd_enb, lcd_oper, lcd_data, busy, frame_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        count_rst_cycles(n);
        checks++;
        if (n !== RST_C) begin
            errors++;
            $display("FAIL reset_len got %0d cycles need %0d", n, RST_C);
        end
        wait_strobes(4, 40, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL init_timeout got %0d strobes need 4", q.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({q[k].oper, q[k].data} !== {1'b0, init_b[k]}) begin
                errors++;
                $display("FAIL init_byte%0d got %b/%h need 0/%h", k, q[k].oper, q[k].data, init_b[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k+1].cyc - q[k].cyc !== 2) begin
                errors++;
                $display("FAIL init_spacing%0d got %0d need 2", k, q[k+1].cyc - q[k].cyc);
            end
        end
    endtask

    task automatic test_first_frame;
        bit to;
        wait_strobes(26, 100, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL frame1_timeout got %0d strobes need 26", q.size());
        end
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[4+i].oper, q[4+i].data} !== exp_byte("> 00:15:30", "  01:20:00", i)) begin
                errors++;
                $display("FAIL frame1_byte%0d got %h need %h", i, {q[4+i].oper, q[4+i].data},
                         exp_byte("> 00:15:30", "  01:20:00", i));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({fd_cnt, busy} !== {32'd1, 1'b0} || q.size() != 26) begin
            errors++;
            $display("FAIL frame1_done got fd=%0d busy=%b strobes=%0d need 1 0 26", fd_cnt, busy, q.size());
        end
    endtask

    task automatic test_rdy_throttle;
        int base = q.size();
        int fd0 = fd_cnt;
        int rv0 = rdy_viol;
        int cv0 = consec_viol;
        bit to = 0;
        bit seen;
        @(posedge clk);
        #1 time_a = 24'h001531;
        for (int k = 0; k < 22; k++) begin
            seen = 0;
            for (int w = 0; w < 50 && !seen; w++) begin
                @(negedge clk);
                if (lcd_enb) seen = 1;
            end
            if (!seen) to = 1;
            @(posedge clk);
            #1 lcd_rdy = 1'b0;
            repeat (5) @(posedge clk);
            #1 lcd_rdy = 1'b1;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (to || q.size() - base != 22) begin
            errors++;
            $display("FAIL throttle_count got %0d strobes need 22", q.size() - base);
        end
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base+i].oper, q[base+i].data} !== exp_byte("> 00:15:31", "  01:20:00", i)) begin
                errors++;
                $display("FAIL throttle_byte%0d got %h need %h", i, {q[base+i].oper, q[base+i].data},
                         exp_byte("> 00:15:31", "  01:20:00", i));
            end
        end
        checks++;
        if (rdy_viol != rv0 || consec_viol != cv0 || fd_cnt != fd0 + 1) begin
            errors++;
            $display("FAIL throttle_rules got rdyviol=%0d consec=%0d fd=%0d need 0 0 1",
                     rdy_viol - rv0, consec_viol - cv0, fd_cnt - fd0);
        end
    endtask

    task automatic test_midframe_change;
        int base = q.size();
        int fd0 = fd_cnt;
        bit to;
        @(posedge clk);
        #1 time_a = 24'h001530;
        wait_strobes(base + 4, 50, to);
        @(posedge clk);
        #1 time_a = 24'h001529;
        wait_strobes(base + 44, 300, to);
        repeat (4) @(negedge clk);
        checks++;
        if (to || q.size() != base + 44 || fd_cnt != fd0 + 2) begin
            errors++;
            $display("FAIL mid_count got %0d strobes fd=%0d need 44 2", q.size() - base, fd_cnt - fd0);
        end
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base+i].oper, q[base+i].data} !== exp_byte("> 00:15:30", "  01:20:00", i)) begin
                errors++;
                $display("FAIL mid_old_byte%0d got %h need %h", i, {q[base+i].oper, q[base+i].data},
                         exp_byte("> 00:15:30", "  01:20:00", i));
            end
            checks++;
            if ({q[base+22+i].oper, q[base+22+i].data} !== exp_byte("> 00:15:29", "  01:20:00", i)) begin
                errors++;
                $display("FAIL mid_new_byte%0d got %h need %h", i, {q[base+22+i].oper, q[base+22+i].data},
                         exp_byte("> 00:15:29", "  01:20:00", i));
            end
        end
    endtask

    task automatic test_markers;
        int base = q.size();
        bit to;
        @(posedge clk);
        #1 set_mode = 1'b1;
        time_b = 24'h01A000;
        wait_strobes(base + 22, 100, to);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base+i].oper, q[base+i].data} !== exp_byte("* 00:15:29", "* 01:?0:00", i)) begin
                errors++;
                $display("FAIL setmode_byte%0d got %h need %h", i, {q[base+i].oper, q[base+i].data},
                         exp_byte("* 00:15:29", "* 01:?0:00", i));
            end
        end
        base = q.size();
        @(posedge clk);
        #1 set_mode = 1'b0;
        active_b = 1'b1;
        wait_strobes(base + 22, 100, to);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base+i].oper, q[base+i].data} !== exp_byte("  00:15:29", "> 01:?0:00", i)) begin
                errors++;
                $display("FAIL activeb_byte%0d got %h need %h", i, {q[base+i].oper, q[base+i].data},
                         exp_byte("  00:15:29", "> 01:?0:00", i));
            end
        end
    endtask

    task automatic test_refresh;
        int base = q.size();
        bit to;
        wait_strobes(base + 1, REF_C + 50, to);
        checks++;
        if (to || q[base].cyc - fd_cyc != REF_C + 1 || q[base].data !== 8'h80) begin
            errors++;
            $display("FAIL refresh_start got delay=%0d data=%h need %0d 80", q[base].cyc - fd_cyc,
                     q[base].data, REF_C + 1);
        end
        wait_strobes(base + 22, 100, to);
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base+i].oper, q[base+i].data} !== exp_byte("  00:15:29", "> 01:?0:00", i)) begin
                errors++;
                $display("FAIL refresh_byte%0d got %h need %h", i, {q[base+i].oper, q[base+i].data},
                         exp_byte("  00:15:29", "> 01:?0:00", i));
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int base = q.size();
        int fd0 = fd_cnt;
        int n_abort;
        int base2;
        int n;
        bit to;
        logic [7:0] init_b [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        @(posedge clk);
        #1 time_b = 24'h012000;
        active_b = 1'b0;
        wait_strobes(base + 14, 60, to);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lcd_enb, lcd_rst, busy} !== 3'b011) begin
            errors++;
            $display("FAIL midrst_outputs got enb=%b rst=%b busy=%b need 0 1 1", lcd_enb, lcd_rst, busy);
        end
        n_abort = q.size();
        @(posedge clk);
        #1 rst = 1'b0;
        base2 = q.size();
        count_rst_cycles(n);
        checks++;
        if (n !== RST_C || base2 != n_abort) begin
            errors++;
            $display("FAIL midrst_len got %0d cycles extra=%0d need %0d 0", n, base2 - n_abort, RST_C);
        end
        wait_strobes(base2 + 26, 120, to);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({q[base2+k].oper, q[base2+k].data} !== {1'b0, init_b[k]}) begin
                errors++;
                $display("FAIL midrst_init%0d got %b/%h need 0/%h", k, q[base2+k].oper, q[base2+k].data, init_b[k]);
            end
        end
        for (int i = 0; i < 22; i++) begin
            checks++;
            if ({q[base2+4+i].oper, q[base2+4+i].data} !== exp_byte("> 00:15:29", "  01:20:00", i)) begin
                errors++;
                $display("FAIL midrst_frame_byte%0d got %h need %h", i, {q[base2+4+i].oper, q[base2+4+i].data},
                         exp_byte("> 00:15:29", "  01:20:00", i));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fd_cnt != fd0 + 1) begin
            errors++;
            $display("FAIL midrst_done got %0d pulses need 1", fd_cnt - fd0);
        end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_rdy_throttle;
        test_midframe_change;
        test_markers;
        test_refresh;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Sequences the character-LCD driver for the chess timer display.
- After reset it resets and initialises the driver, then redraws two 10-character lines, one per player, each showing marker + "HH:MM:SS".
- It issues one command or data byte per driver handshake.
- Sits between the time-keeping logic (BCD clock values, active player, set mode) and the FPGA-to-LCD driver. It replaces ad-hoc serial framing with a deterministic frame schedule.

Parameters:
- RST_CYCLES, 16: cycles lcd_rst is held high after reset.
- REFRESH_CYCLES, 1000000: maximum cycles between frame starts while idle (periodic redraw).
- CNT_W, 20: width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- time_a  in  24  player A time, BCD {H1,H0,M1,M0,S1,S0}, 4 bits each, MSB first.
- time_b  in  24  player B time, same format.
- active_b  in  1  1 = player B running, 0 = player A running.
- set_mode  in  1  1 = times being edited.
- lcd_rdy  in  1  driver ready to accept a transfer.
- lcd_rst  out  1  driver reset.
- lcd_enb  out  1  one-cycle transfer strobe.
- lcd_oper  out  1  0 = command byte, 1 = data (character) byte.
- lcd_data  out  8  byte for the current transfer.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.

Behaviour:
- Reset values: lcd_rst=1, lcd_enb=0, lcd_oper=0, lcd_data=0x00, busy=1, frame_done=0. State becomes DRV_RST and all counters are cleared. A reset asserted mid-frame aborts the frame at the next edge; no further strobes are issued.
- Transfer rule:
  - lcd_enb is asserted for exactly one cycle, only in an ISSUE cycle where lcd_rdy=1.
  - lcd_oper and lcd_data are valid in that cycle and hold until the next issue.
  - Every issue is followed by one mandatory HOLD cycle (lcd_enb=0). The next issue occurs at the first later cycle with lcd_rdy=1.
  - If lcd_rdy stays 0, the block waits indefinitely with no timeout.
- States and transitions:
  - DRV_RST: lcd_rst=1 for RST_CYCLES cycles, then goes to INIT.
  - INIT: issues commands 0x38, 0x0C, 0x06, 0x01 in that order (lcd_oper=0), then goes to IDLE.
  - IDLE: busy=0; refresh counter increments. A frame starts (go to LINE1_ADDR) when either:
    - the live inputs {time_a, time_b, active_b, set_mode} differ from the snapshot; or
    - the refresh counter equals REFRESH_CYCLES-1.
  - Frame start: snapshot registers load the live inputs and the refresh counter clears, both in the same cycle.
  - LINE1_ADDR: command 0x80. LINE1_CHARS: 10 data bytes built from the snapshot of time_a.
  - LINE2_ADDR: command 0xC0. LINE2_CHARS: 10 data bytes built from the snapshot of time_b.
  - After LINE2_CHARS the block returns to IDLE. frame_done pulses in the cycle after the 22nd frame strobe.
- Line format, character indices 0..9:
  - Index 0 is the marker: '*'(0x2A) if set_mode; else '>'(0x3E) on the running player's line; else ' '(0x20).
  - Index 1 is ' '(0x20).
  - Indices 2-3 hours, 4 ':'(0x3A), 5-6 minutes, 7 ':', 8-9 seconds.
  - Digit byte = 0x30 + nibble for nibble 0..9; nibble 10..15 -> '?'(0x3F).
- All frame bytes come from the snapshot. Input changes during a frame do not alter the frame in progress. They trigger a new frame on the first IDLE cycle afterwards.
- A frame is exactly 22 transfers; INIT is exactly 4 and occurs only after reset.
- The refresh counter saturates at REFRESH_CYCLES-1 and does not wrap.

Test Plan:
- Reset, RST_CYCLES=16, lcd_rdy=1 always -> lcd_rst high 16 cycles; then strobes with oper=0 carrying 0x38, 0x0C, 0x06, 0x01, spaced 2 cycles apart.
- time_a=0x001530, time_b=0x012000, active_b=0, set_mode=0 -> line 1 bytes 0x80 then "> 00:15:30"; line 2 bytes 0xC0 then "  01:20:00"; frame_done pulses once; total 22 strobes.
- lcd_rdy toggles 0 for 5 cycles between transfers -> no strobe while rdy=0; byte order and count unchanged; never two strobes in consecutive cycles.
- time_a changes 0x001530->0x001529 mid-line-1 -> current frame still shows "30"; the next frame starts from IDLE and shows "29".
- set_mode=1, time_b nibble 0xA -> both markers '*'; that digit position shows 0x3F.
- rst asserted during LINE2_CHARS -> lcd_enb=0 from the next cycle, lcd_rst=1, and INIT repeats in full.
